// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latrsnq_array.sv
// Purpose: N-channel clocked set/clear/load register with sticky change flags and a conflict detector.
// Latency: 1 cycle from inputs to Q, CHG and CONFLICT (and CNT); no combinational input-to-output path.
// Backpressure: none, because every channel updates unconditionally on each rising edge of CLK.
// Optional feature: define GF180MCU_LATRS_ARRAY_CONFLICT_CNT_EN to add the saturating CNT conflict counter.
module gf180mcu_fd_sc_mcu9t5v0__latrsnq_array #(
    parameter int               WIDTH        = 8,
    parameter int               RST_DOMINANT = 1,
    parameter logic [WIDTH-1:0] INIT         = '0,
    parameter int               CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] RN,
    input  logic [WIDTH-1:0] SETN,
    input  logic             CHG_CLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] CHG,
    output logic             CONFLICT
`ifdef GF180MCU_LATRS_ARRAY_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0] CNT
`endif
);

    // Stop elaboration on out-of-range parameters rather than building odd hardware.
    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 2 || CNT_W > 16) begin : g_param_check
        $error("latrsnq_array: WIDTH must be 1..64 and CNT_W must be 2..16");
    end

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] chg_nxt;
    logic             conflict_nxt;

    // Next-state logic: load under enable, then apply set and clear with the chosen dominance.
    always_comb begin
        load_val     = (E & D) | (~E & Q);
        q_nxt        = load_val;
        conflict_nxt = |(~RN & ~SETN);
        if (RST_DOMINANT != 0) begin
            // Clear is applied last, so it overrides set when both are asserted.
            q_nxt = (load_val | ~SETN) & RN;
        end else begin
            // Set is applied last, so it overrides clear when both are asserted.
            q_nxt = (load_val & RN) | ~SETN;
        end
        // A fresh change re-arms its flag even when the clear is asserted in the same cycle.
        chg_nxt = (CHG & ~{WIDTH{CHG_CLR}}) | (q_nxt ^ Q);
    end

    // State register: reset overrides every pending set, clear, load and flag clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q        <= INIT;
            CHG      <= '0;
            CONFLICT <= 1'b0;
        end else begin
            Q        <= q_nxt;
            CHG      <= chg_nxt;
            CONFLICT <= conflict_nxt;
        end
    end

`ifdef GF180MCU_LATRS_ARRAY_CONFLICT_CNT_EN
    // Conflict-cycle counter: counts with CONFLICT's next value and sticks at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT <= '0;
        end else if (conflict_nxt && (CNT != {CNT_W{1'b1}})) begin
            CNT <= CNT + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latrsnq_array.sv
// Directed bench: two instances share stimulus, one clear-dominant and one set-dominant.
// Inputs change 1 time unit after the rising edge and outputs are sampled at that same point.
// CNT is checked only when the counter macro is defined.
module tb_gf180mcu_fd_sc_mcu9t5v0__latrsnq_array;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] E, D, RN, SETN;
    logic       CHG_CLR;

    logic [7:0] q_rd, chg_rd, q_sd, chg_sd;
    logic       conf_rd, conf_sd;
`ifdef GF180MCU_LATRS_ARRAY_CONFLICT_CNT_EN
    logic [1:0] cnt_rd, cnt_sd;
`endif

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu9t5v0__latrsnq_array #(
        .WIDTH(8), .RST_DOMINANT(1), .INIT(8'hA5), .CNT_W(2)
    ) dut_rd (
        .CLK(CLK), .RST(RST), .E(E), .D(D), .RN(RN), .SETN(SETN), .CHG_CLR(CHG_CLR),
        .Q(q_rd), .CHG(chg_rd), .CONFLICT(conf_rd)
`ifdef GF180MCU_LATRS_ARRAY_CONFLICT_CNT_EN
        , .CNT(cnt_rd)
`endif
    );

    gf180mcu_fd_sc_mcu9t5v0__latrsnq_array #(
        .WIDTH(8), .RST_DOMINANT(0), .INIT(8'hA5), .CNT_W(2)
    ) dut_sd (
        .CLK(CLK), .RST(RST), .E(E), .D(D), .RN(RN), .SETN(SETN), .CHG_CLR(CHG_CLR),
        .Q(q_sd), .CHG(chg_sd), .CONFLICT(conf_sd)
`ifdef GF180MCU_LATRS_ARRAY_CONFLICT_CNT_EN
        , .CNT(cnt_sd)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag,
                           input logic [7:0] eq_rd, input logic [7:0] eq_sd,
                           input logic [7:0] ec_rd, input logic [7:0] ec_sd,
                           input logic ecf, input logic [1:0] ecnt);
        chk({tag, " q_rd"},   {8'h0, q_rd},   {8'h0, eq_rd});
        chk({tag, " q_sd"},   {8'h0, q_sd},   {8'h0, eq_sd});
        chk({tag, " chg_rd"}, {8'h0, chg_rd}, {8'h0, ec_rd});
        chk({tag, " chg_sd"}, {8'h0, chg_sd}, {8'h0, ec_sd});
        chk({tag, " conf_rd"}, {15'h0, conf_rd}, {15'h0, ecf});
        chk({tag, " conf_sd"}, {15'h0, conf_sd}, {15'h0, ecf});
`ifdef GF180MCU_LATRS_ARRAY_CONFLICT_CNT_EN
        chk({tag, " cnt_rd"}, {14'h0, cnt_rd}, {14'h0, ecnt});
        chk({tag, " cnt_sd"}, {14'h0, cnt_sd}, {14'h0, ecnt});
`else
        if (ecnt === 2'bxx) $error("FAIL %s: unexpected unknown count", tag);
`endif
    endtask

    initial begin
        RST = 1'b1; E = 8'h00; D = 8'h00; RN = 8'hFF; SETN = 8'hFF; CHG_CLR = 1'b0;

        // Reset held for two edges.
        step(); step();
        chk_all("reset", 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 2'd0);

        // Idle after reset: Q holds INIT and no flags appear.
        RST = 1'b0;
        step();
        chk_all("idle1", 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 2'd0);
        step();
        chk_all("idle2", 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 2'd0);

        // Full-width load: A5 -> 3C flips bits 0,3,4,7.
        E = 8'hFF; D = 8'h3C;
        step();
        chk_all("load", 8'h3C, 8'h3C, 8'h99, 8'h99, 1'b0, 2'd0);

        // Flag clear coinciding with a new change on bit 0: the new change survives.
        CHG_CLR = 1'b1; D = 8'h3D;
        step();
        chk_all("clr_and_chg", 8'h3D, 8'h3D, 8'h01, 8'h01, 1'b0, 2'd0);

        // Steady enable with steady data: flags stay sticky, nothing new.
        CHG_CLR = 1'b0;
        step();
        chk_all("steady", 8'h3D, 8'h3D, 8'h01, 8'h01, 1'b0, 2'd0);

        // Flag clear with no activity.
        CHG_CLR = 1'b1;
        step();
        chk_all("clr_only", 8'h3D, 8'h3D, 8'h00, 8'h00, 1'b0, 2'd0);
        CHG_CLR = 1'b0;

        // Channel 0: set, clear, enable and D=1 together. Dominance decides Q[0].
        E = 8'h01; D = 8'h01; RN = 8'hFE; SETN = 8'hFE;
        step();
        chk_all("prio_ch0", 8'h3C, 8'h3D, 8'h01, 8'h00, 1'b1, 2'd1);

        // Channel 1: set only.
        E = 8'h00; RN = 8'hFF; SETN = 8'hFD;
        step();
        chk_all("set_ch1", 8'h3E, 8'h3F, 8'h03, 8'h02, 1'b0, 2'd1);

        // Reset pulsed between edges has no effect.
        SETN = 8'hFF;
        RST = 1'b1; #2; RST = 1'b0; #1;
        chk_all("rst_glitch", 8'h3E, 8'h3F, 8'h03, 8'h02, 1'b0, 2'd1);

        // Reset mid-operation alongside a full-width set.
        RST = 1'b1; SETN = 8'h00; CHG_CLR = 1'b0;
        step();
        chk_all("rst_mid", 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 2'd0);

        // Conflict on every channel for five cycles; counter saturates at 3.
        RST = 1'b0; RN = 8'h00; SETN = 8'h00;
        step();
        chk_all("sat1", 8'h00, 8'hFF, 8'hA5, 8'h5A, 1'b1, 2'd1);
        step();
        chk_all("sat2", 8'h00, 8'hFF, 8'hA5, 8'h5A, 1'b1, 2'd2);
        step();
        chk_all("sat3", 8'h00, 8'hFF, 8'hA5, 8'h5A, 1'b1, 2'd3);
        step();
        chk_all("sat4", 8'h00, 8'hFF, 8'hA5, 8'h5A, 1'b1, 2'd3);
        step();
        chk_all("sat5", 8'h00, 8'hFF, 8'hA5, 8'h5A, 1'b1, 2'd3);

        // Conflict removed: counter holds at its ceiling.
        RN = 8'hFF; SETN = 8'hFF;
        step();
        chk_all("sat_hold", 8'h00, 8'hFF, 8'hA5, 8'h5A, 1'b0, 2'd3);

        // Reset while a conflict is present: conflict is not registered.
        RST = 1'b1; RN = 8'h00; SETN = 8'h00;
        step();
        chk_all("rst_conf", 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 2'd0);
        RST = 1'b0; RN = 8'hFF; SETN = 8'hFF;
        step();
        chk_all("post_rst", 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
